data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
Arbitrates ownership of the processor's shared 16-bit data bus among up to NUM_REQ drivers (PC, ALU/register file, RAM, ROM data). It grants exactly one owner at a time and inserts one dead turnaround cycle between owners so no two drivers ever overlap. It also bounds each tenure with a hold timeout. It sits beside the fetch-decode-execute sequencer and converts its per-unit read enables into registered, conflict-free drive grants.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
ID_WIDTH, 2, width of grant_id; must satisfy 2^ID_WIDTH >= NUM_REQ.
PRIORITY_REQ, 0, index of the fixed-priority requester (PC fetch); must be < NUM_REQ.
MAX_HOLD, 8, maximum consecutive cycles one owner may hold the bus; legal range 1..2^CNT_WIDTH-1.
CNT_WIDTH, 4, width of hold_count.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous reset, active-high.
req  in  NUM_REQ  level request per requester; held high for as long as the bus is wanted.
release  in  NUM_REQ  one-cycle done pulse per requester; only the current owner's bit has effect.
grant  out  NUM_REQ  one-hot drive enable (all zero when no owner).
grant_valid  out  1  high when any grant bit is set.
grant_id  out  ID_WIDTH  index of current owner; 0 when grant_valid=0.
hold_count  out  CNT_WIDTH  cycles held by current owner, counting from 1; 0 when no owner.
timeout  out  1  one-cycle pulse when an owner is forcibly revoked.
state_output  out  2  current FSM state (debug).

Behaviour:
- All outputs are registered.
- On reset (asynchronous, takes effect immediately even mid-tenure):
  - grant=0, grant_valid=0, grant_id=0, hold_count=0, timeout=0.
  - state=IDLE; last_owner=NUM_REQ-1.
- FSM states: IDLE=2'd0, GRANT=2'd1, TURN=2'd2. Encoding 2'd3 is illegal and goes to IDLE on the next edge with all outputs cleared.
- IDLE:
  - If any req bit is set, arbitrate. At the next edge go to GRANT with the winner's grant bit set and hold_count=1.
  - Otherwise stay in IDLE.
  - Grant latency from first req sample is exactly 1 cycle.
- Arbitration, evaluated in IDLE and at the end of TURN:
  - req[PRIORITY_REQ] wins outright.
  - Exception: if last_owner==PRIORITY_REQ and any other req bit is set, the priority requester is skipped for this round (anti-starvation).
  - Otherwise round-robin: search from last_owner+1 upward, wrapping modulo NUM_REQ; the first set req bit wins.
  - last_owner is updated on every grant.
- GRANT, with the owner holding the bus. Leave GRANT for TURN at the next edge when any of the following holds:
  - (a) release[owner]=1; or
  - (b) req[owner]=0; or
  - (c) hold_count==MAX_HOLD. This is a forced revoke: timeout=1 during the TURN cycle only.
  - Otherwise stay and increment hold_count. hold_count never exceeds MAX_HOLD.
- release and req on the same cycle from the owner: release wins and the bus is relinquished.
- release bits from non-owners are ignored in all states.
- TURN (turnaround):
  - Exactly one cycle with grant=0, grant_valid=0, hold_count=0.
  - At its end, arbitrate: go to GRANT if any req bit is set, else go to IDLE.
  - Consequence: at least one dead bus cycle between consecutive owners, including when the same requester is re-granted.
- A forced revoke does not penalise the owner beyond round-robin order. If it is the only requester, it is re-granted after TURN.
- Invariant, checked by assertion in the bench: popcount(grant)<=1 on every cycle, and grant[i]=1 implies grant_id==i.

Test Plan:
1. Reset, then req=4'b0100 from cycle 0 and release[2] pulsed in cycle 3 -> grant=4'b0100 in cycles 1–3 with hold_count 1,2,3; grant=0 in cycle 4; state IDLE in cycle 5.
2. Round-robin: req=4'b1110 held high, each owner releases after 1 cycle, PRIORITY_REQ=0 idle -> owners in order 1,2,3,1 with exactly one grant=0 cycle between each.
3. Priority and anti-starvation: req=4'b0011, requester 0 re-requests immediately after each release -> grants 0,1,0,1; requester 1 is never skipped twice.
4. Timeout with MAX_HOLD=8: req[1] held high and no release -> grant[1] for exactly 8 cycles (hold_count reaches 8); timeout=1 for one cycle with grant=0; then grant[1] again with hold_count=1.
5. Reset asserted mid-tenure (hold_count=5, grant=4'b1000) -> grant=0 and state=IDLE immediately, before the next clock edge; after reset is deasserted, a pending req is granted after 1 cycle.
6. Owner drops req without release in cycle 2 while req[3] is pending -> TURN in cycle 3; grant=4'b1000 in cycle 4; no timeout pulse.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: one-owner-at-a-time data bus grants with priority/round-robin arbitration, turnaround cycle and hold timeout.
module data_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_WIDTH = 2,
  parameter int PRIORITY_REQ = 0,
  parameter int MAX_HOLD = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   release_req,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 grant_valid,
  output logic [ID_WIDTH-1:0]  grant_id,
  output logic [CNT_WIDTH-1:0] hold_count,
  output logic                 timeout,
  output logic [1:0]           state_output
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;
  localparam logic [NUM_REQ-1:0] PRI_MASK = NUM_REQ'(1) << PRIORITY_REQ;
  state_t state;
  logic [ID_WIDTH-1:0] last_owner, win;
  logic skip, own_req, own_rel, at_max;
  assign state_output = state;
  assign own_req = |(req & grant);
  assign own_rel = |(release_req & grant);
  assign at_max = hold_count == CNT_WIDTH'(MAX_HOLD);
  // Descending scan so the nearest requester after last_owner is assigned last and wins.
  always_comb begin
    skip = last_owner == ID_WIDTH'(PRIORITY_REQ) && |(req & ~PRI_MASK);
    win = ID_WIDTH'(PRIORITY_REQ);
    if (!req[PRIORITY_REQ] || skip) begin
      win = '0;
      for (int k = NUM_REQ; k >= 1; k--)
        if ((req & (NUM_REQ'(1) << ((int'(last_owner) + k) % NUM_REQ))) != '0)
          win = ID_WIDTH'((int'(last_owner) + k) % NUM_REQ);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold_count  <= '0;
      timeout     <= 1'b0;
      last_owner  <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE, TURN: begin
          timeout <= 1'b0;
          if (|req) begin
            state       <= GRANT;
            grant       <= NUM_REQ'(1) << win;
            grant_valid <= 1'b1;
            grant_id    <= win;
            hold_count  <= CNT_WIDTH'(1);
            last_owner  <= win;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (own_rel || !own_req || at_max) begin
            state       <= TURN;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            hold_count  <= '0;
            timeout     <= !own_rel && own_req;
          end else begin
            hold_count <= hold_count + CNT_WIDTH'(1);
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
          grant_id    <= '0;
          hold_count  <= '0;
          timeout     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: table-driven vectors plus hand-written timeout and async-reset sequences.
module tb_data_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] release_req = '0;
  logic [3:0] grant;
  logic grant_valid, timeout;
  logic [1:0] grant_id, state_output;
  logic [3:0] hold_count;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst;
    logic [3:0] req, rel, grant;
    logic [1:0] id;
    logic [3:0] hold;
    logic to;
    logic [1:0] st;
  } vec_t;
  vec_t vecs[$];

  data_bus_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .release_req(release_req),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .hold_count(hold_count), .timeout(timeout), .state_output(state_output)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [3:0] rq, logic [3:0] rl, logic [3:0] g,
                              logic [1:0] id, logic [3:0] h, logic to, logic [1:0] st);
    vec_t v;
    v.rst = rst; v.req = rq; v.rel = rl; v.grant = g; v.id = id; v.hold = h; v.to = to; v.st = st;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [3:0] g, logic [1:0] id, logic [3:0] h, logic to, logic [1:0] st);
    chk({tag, " grant"}, int'(grant), int'(g));
    chk({tag, " grant_valid"}, int'(grant_valid), int'(|g));
    chk({tag, " grant_id"}, int'(grant_id), int'(id));
    chk({tag, " hold_count"}, int'(hold_count), int'(h));
    chk({tag, " timeout"}, int'(timeout), int'(to));
    chk({tag, " state"}, int'(state_output), int'(st));
  endtask

  // Bus invariant: at most one driver, and grant_id names it.
  always @(negedge clk) begin
    checks++;
    assert ($countones(grant) <= 1 && (grant == '0 || grant == (4'b1 << grant_id)))
    else begin
      errors++;
      $display("FAIL invariant: grant=%b grant_id=%0d", grant, grant_id);
    end
  end

  initial begin
    // single owner, release, non-owner release ignored
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0001, 4'b0100, 2, 2, 0, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 3, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    // round-robin 1,2,3,1 with release-while-requesting
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b0000, 4'b0010, 1, 1, 0, 1));
    vecs.push_back(mk(0, 4'b1110, 4'b0010, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b1110, 4'b0000, 4'b0100, 2, 1, 0, 1));
    vecs.push_back(mk(0, 4'b1110, 4'b0100, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b1110, 4'b0000, 4'b1000, 3, 1, 0, 1));
    vecs.push_back(mk(0, 4'b1110, 4'b1000, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b1110, 4'b0000, 4'b0010, 1, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    // priority with anti-starvation: 0,1,0,1
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 4'b0010, 1, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0010, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 4'b0010, 1, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    // owner drops req without release while req[3] pending
    vecs.push_back(mk(0, 4'b1100, 4'b0000, 4'b0100, 2, 1, 0, 1));
    vecs.push_back(mk(0, 4'b1100, 4'b0000, 4'b0100, 2, 2, 0, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));

    #1 chk_all("reset", 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      req = vecs[i].req;
      release_req = vecs[i].rel;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, vecs[i].hold, vecs[i].to, vecs[i].st);
    end

    // hold timeout: 8 cycles, one timeout/turn cycle, then re-grant
    @(negedge clk);
    reset = 1'b1; req = '0; release_req = '0;
    @(negedge clk);
    reset = 1'b0; req = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1 chk_all($sformatf("hold%0d", i), 4'b0010, 1, 4'(i), 0, 1);
    end
    @(posedge clk);
    #1 chk_all("timeout", 4'b0000, 0, 0, 1, 2);
    @(posedge clk);
    #1 chk_all("regrant", 4'b0010, 1, 1, 0, 1);

    // asynchronous reset mid-tenure
    @(negedge clk);
    reset = 1'b1; req = '0;
    @(negedge clk);
    reset = 1'b0; req = 4'b1000;
    for (int i = 1; i <= 5; i++) @(posedge clk);
    #1 chk_all("pre_reset", 4'b1000, 3, 5, 0, 1);
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk_all("post_reset", 4'b1000, 3, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
